fft_power_spectrum: RTL and testbench
=====================================

Name: fft_power_spectrum

Overview:
- Sits directly upstream of the mel triangular filter bank.
- Consumes the complex FFT output stream and computes the per-bin power |X[k]|^2 = re^2 + im^2.
- Tags each result with bin index k and forwards only the first FFT_SIZE/2 bins, as power_out/k_out. These feed the power_in/k_in inputs of every triangular filter.
- Tracks frame alignment with tlast and flags framing errors, resynchronising to the next frame.

Parameters:
- FFT_SIZE, 1024: bins per FFT frame; power of two, >= 4.
- IN_WIDTH, 16: signed width of each of re and im.
- POWER_SHIFT, 4: right-shift amount, used only when FFT_POWER_SHIFT_EN is defined.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- fft_tdata_in  input  2*IN_WIDTH  {im, re}; re in [IN_WIDTH-1:0]; both signed two's complement.
- fft_tvalid_in  input  1  beat valid.
- fft_tlast_in  input  1  last beat of frame (bin FFT_SIZE-1).
- fft_tready_out  output  1  ready; always 1 when out of reset.
- power_out  output  2*IN_WIDTH  bin power; 0 whenever valid_out is 0.
- k_out  output  $clog2(FFT_SIZE/2)  bin index (9 bits at default).
- valid_out  output  1  power_out/k_out valid this cycle.
- frame_done_out  output  1  one-cycle pulse coincident with the valid_out of bin FFT_SIZE/2-1.
- err_out  output  1  sticky framing error; cleared only by reset.

Behaviour:
- Reset (rst_in low, asynchronous), all outputs and state go to:
  - power_out = 0, k_out = 0, valid_out = 0, frame_done_out = 0, err_out = 0, fft_tready_out = 0.
  - State IDLE, bin counter 0, all pipeline valids cleared.
- Reset release: fft_tready_out = 1 from the first clk_in edge after rst_in goes high.
- Handshake:
  - A beat is accepted when fft_tvalid_in && fft_tready_out.
  - tvalid gaps stall the bin counter; the pipeline keeps draining.
  - No backpressure exists downstream.
- Pipeline: 3 stages, fixed latency 3 cycles from the accept edge to valid_out.
  - S1: register re, im, k and the forward flag (k < FFT_SIZE/2).
  - S2: re*re and im*im as unsigned 2*IN_WIDTH-1 bit values; (-2^15)^2 = 2^30 fits.
  - S3: sum into 2*IN_WIDTH bits. Maximum is 2^31, so no overflow and no saturation is needed.
- Bins FFT_SIZE/2..FFT_SIZE-1 (mirror half) are counted but never raise valid_out.
- State machine:
  - IDLE: accepted beat is bin 0 → STREAM; counter = 1.
    - If that beat has tlast, set err_out and stay in IDLE.
  - STREAM: each accept increments the counter.
    - tlast with counter == FFT_SIZE-1 → IDLE, counter 0 (normal end of frame).
    - tlast with counter != FFT_SIZE-1 (early tlast) → set err_out, IDLE, counter 0. The beat itself is still processed if its k < FFT_SIZE/2.
    - Counter == FFT_SIZE-1 with no tlast (missing tlast) → set err_out, go to RESYNC. The beat is processed normally.
  - RESYNC: accepted beats are discarded (no valid_out, counter held at 0). An accepted tlast beat → IDLE.
- Bins arriving after an early tlast start a new frame at bin 0.
- frame_done_out: asserted only when bin FFT_SIZE/2-1 exits S3. If an early tlast cuts a frame short before that bin, no pulse is produced.
- Reset mid-frame: in-flight pipeline contents are dropped and no valid_out is produced for them.

Optional Feature:
- FFT_POWER_SHIFT_EN defined: power_out = (sum + 2^(POWER_SHIFT-1)) >> POWER_SHIFT, round-half-up. The addition is done in 2*IN_WIDTH+1 bits, so there is no wrap. Latency is unchanged (rounding folded into S3).
- FFT_POWER_SHIFT_EN undefined: power_out = raw sum. The POWER_SHIFT parameter is ignored.

Test Plan:
- Flat input: re=100, im=0 for all 1024 beats, tlast on beat 1023, continuous tvalid.
  - valid_out high for exactly 512 cycles, starting 3 cycles after the first accept.
  - power_out=10000; k_out=0..511.
  - frame_done_out pulses with k_out=511.
  - No valid_out for beats 512..1023; err_out=0.
- Extremes: re=-32768, im=-32768 → power_out=0x8000_0000. re=3, im=-4 → 25. With FFT_POWER_SHIFT_EN and POWER_SHIFT=4: 0x0800_0000 and 2 respectively.
- Gapped tvalid: tvalid toggling 1,0,1,0 → k_out increments only on valid beats; power values are unchanged; still 512 valids per frame.
- Early tlast on bin 300 → err_out=1 after that beat; no frame_done_out. The next frame (bin 0 onward) produces 512 valids and a frame_done_out.
- Missing tlast at bin 1023 → err_out=1, enter RESYNC. 50 further beats give no valid_out; a beat with tlast returns to IDLE; the following full frame is normal.
- Reset mid-frame: rst_in low at bin 200 for 2 cycles → all outputs 0 immediately, with no valid_out for bins in flight. A full frame after release gives 512 valids starting at k_out=0.

Source files
------------

// File: rtl/fft_power_spectrum.sv
// Per-bin power |X[k]|^2 of a complex FFT stream, forwarding bins 0..FFT_SIZE/2-1 with frame checking.
// Optional FFT_POWER_SHIFT_EN: round-half-up right shift of the power by POWER_SHIFT bits.
module fft_power_spectrum #(
    parameter int FFT_SIZE    = 1024,
    parameter int IN_WIDTH    = 16,
    parameter int POWER_SHIFT = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [2*IN_WIDTH-1:0]           fft_tdata_in,
    input  logic                            fft_tvalid_in,
    input  logic                            fft_tlast_in,
    output logic                            fft_tready_out,
    output logic [2*IN_WIDTH-1:0]           power_out,
    output logic [$clog2(FFT_SIZE/2)-1:0]   k_out,
    output logic                            valid_out,
    output logic                            frame_done_out,
    output logic                            err_out
);

    localparam int PW = 2 * IN_WIDTH;
    localparam int CW = $clog2(FFT_SIZE);
    localparam int KW = $clog2(FFT_SIZE / 2);
    localparam logic [CW-1:0] LAST_BIN  = CW'(FFT_SIZE - 1);
    localparam logic [KW-1:0] HALF_LAST = KW'(FFT_SIZE / 2 - 1);

    typedef enum logic [1:0] {IDLE, STREAM, RESYNC} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  rdy_q, rdy_d;

    logic                  accept;
    logic [CW-1:0]         beat_k;
    logic                  s1_vld;

    logic [2:0]            vld_q, vld_d;
    logic signed [IN_WIDTH-1:0] re1_q, re1_d, im1_q, im1_d;
    logic [KW-1:0]         k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [PW-2:0]         sq_re_q, sq_re_d, sq_im_q, sq_im_d;
    logic [PW-1:0]         power_q, power_d;
    logic                  done_q, done_d;

    logic signed [PW-1:0]  prod_re, prod_im;
    logic [PW-1:0]         sum;
`ifdef FFT_POWER_SHIFT_EN
    localparam logic [PW:0] RND = (PW+1)'(1) << (POWER_SHIFT - 1);
    logic [PW:0]           rnd_sum, shifted;
`endif

    assign accept = fft_tvalid_in && rdy_q;

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdy_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fft_tlast_in) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = STREAM;
                        cnt_d   = CW'(1);
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    if (fft_tlast_in) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (cnt_q != LAST_BIN) err_d = 1'b1;
                    end else if (cnt_q == LAST_BIN) begin
                        state_d = RESYNC;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RESYNC: begin
                if (accept && fft_tlast_in) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: the beat in IDLE is always bin 0; RESYNC beats are dropped
    always_comb begin
        beat_k = (state_q == IDLE) ? '0 : cnt_q;
        s1_vld = accept && (state_q != RESYNC) && !beat_k[CW-1];
    end

    always_comb begin
        vld_d   = {vld_q[1:0], s1_vld};
        re1_d   = s1_vld ? $signed(fft_tdata_in[IN_WIDTH-1:0])  : re1_q;
        im1_d   = s1_vld ? $signed(fft_tdata_in[PW-1:IN_WIDTH]) : im1_q;
        k1_d    = s1_vld ? beat_k[KW-1:0] : k1_q;

        prod_re = PW'(re1_q) * PW'(re1_q);
        prod_im = PW'(im1_q) * PW'(im1_q);
        sq_re_d = vld_q[0] ? prod_re[PW-2:0] : sq_re_q;
        sq_im_d = vld_q[0] ? prod_im[PW-2:0] : sq_im_q;
        k2_d    = vld_q[0] ? k1_q : k2_q;

        // Each square is at most 2^(PW-2), so the sum fits PW bits without wrap
        sum     = {1'b0, sq_re_q} + {1'b0, sq_im_q};
`ifdef FFT_POWER_SHIFT_EN
        rnd_sum = {1'b0, sum} + RND;
        shifted = rnd_sum >> POWER_SHIFT;
        power_d = vld_q[1] ? shifted[PW-1:0] : '0;
`else
        power_d = vld_q[1] ? sum : '0;
`endif
        k3_d    = vld_q[1] ? k2_q : k3_q;
        done_d  = vld_q[1] && (k2_q == HALF_LAST);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_q   <= '0;
            re1_q   <= '0;
            im1_q   <= '0;
            k1_q    <= '0;
            sq_re_q <= '0;
            sq_im_q <= '0;
            k2_q    <= '0;
            power_q <= '0;
            k3_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            re1_q   <= re1_d;
            im1_q   <= im1_d;
            k1_q    <= k1_d;
            sq_re_q <= sq_re_d;
            sq_im_q <= sq_im_d;
            k2_q    <= k2_d;
            power_q <= power_d;
            k3_q    <= k3_d;
            done_q  <= done_d;
        end
    end

    assign fft_tready_out = rdy_q;
    assign power_out      = power_q;
    assign k_out          = k3_q;
    assign valid_out      = vld_q[2];
    assign frame_done_out = done_q;
    assign err_out        = err_q;

endmodule

// File: tb/tb_fft_power_spectrum.sv
// Directed bench for fft_power_spectrum: vector table for power values plus framing/reset sequences.
module tb_fft_power_spectrum;

    localparam int N  = 1024;
    localparam int NT = 10;
`ifdef FFT_POWER_SHIFT_EN
    localparam logic [31:0] FLAT_EXP = 32'd625;
`else
    localparam logic [31:0] FLAT_EXP = 32'd10000;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] fft_tdata_in = '0;
    logic        fft_tvalid_in = 1'b0;
    logic        fft_tlast_in = 1'b0;
    logic        fft_tready_out;
    logic [31:0] power_out;
    logic [8:0]  k_out;
    logic        valid_out;
    logic        frame_done_out;
    logic        err_out;

    fft_power_spectrum dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .fft_tdata_in   (fft_tdata_in),
        .fft_tvalid_in  (fft_tvalid_in),
        .fft_tlast_in   (fft_tlast_in),
        .fft_tready_out (fft_tready_out),
        .power_out      (power_out),
        .k_out          (k_out),
        .valid_out      (valid_out),
        .frame_done_out (frame_done_out),
        .err_out        (err_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Output log, sampled on the falling edge
    logic [31:0] vq_pow[$];
    int          vq_k[$];
    int          vq_cyc[$];
    int          dq_k[$];
    int          zero_viol = 0;

    always @(negedge clk_in) begin
        if (rst_in) begin
            if (valid_out) begin
                vq_pow.push_back(power_out);
                vq_k.push_back(int'(k_out));
                vq_cyc.push_back(cyc);
            end else if (power_out != 32'd0) begin
                zero_viol = zero_viol + 1;
            end
            if (frame_done_out) dq_k.push_back(int'(k_out));
        end
    end

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [31:0] exp_raw;
        logic [31:0] exp_shr;
    } vec_t;
    vec_t tab[NT];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic drive(input logic [15:0] re, input logic [15:0] im, input logic last);
        fft_tdata_in  = {im, re};
        fft_tvalid_in = 1'b1;
        fft_tlast_in  = last;
        @(posedge clk_in); #1;
        fft_tvalid_in = 1'b0;
        fft_tlast_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in); #1;
        end
    endtask

    task automatic frame(input int nbeats, input int last_at, input bit gapped,
                         input bit use_tab, output int acc_cyc);
        acc_cyc = cyc;
        for (int b = 0; b < nbeats; b++) begin
            if (use_tab && b < NT) drive(tab[b].re, tab[b].im, b == last_at);
            else                   drive(16'd100, 16'd0, b == last_at);
            if (gapped) idle(1);
        end
    endtask

    // Checks a frame that started at bin 0 with flat data beyond the table entries
    task automatic check_frame(input string nm, input int s, input int ds, input int exp_n,
                               input int exp_done, input bit use_tab);
        int n, kbad, pbad, lim;
        n    = vq_pow.size() - s;
        kbad = 0;
        pbad = 0;
        lim  = (n < exp_n) ? n : exp_n;
        chk({nm, "_valid_count"}, 64'(n), 64'(exp_n));
        for (int i = 0; i < lim; i++) begin
            if (vq_k[s+i] != i) kbad++;
            if (!(use_tab && i < NT) && vq_pow[s+i] != FLAT_EXP) pbad++;
        end
        chk({nm, "_k_seq_errors"}, 64'(kbad), 64'(0));
        chk({nm, "_power_errors"}, 64'(pbad), 64'(0));
        chk({nm, "_done_count"}, 64'(dq_k.size() - ds), 64'(exp_done));
        if (exp_done > 0 && dq_k.size() > ds) chk({nm, "_done_k"}, 64'(dq_k[ds]), 64'(511));
    endtask

    initial begin
        int s, ds, acc;

        tab[0] = '{16'h8000, 16'h8000, 32'h8000_0000, 32'h0800_0000};
        tab[1] = '{16'd3,    16'hFFFC, 32'd25,        32'd2};
        tab[2] = '{16'd100,  16'd0,    32'd10000,     32'd625};
        tab[3] = '{16'd0,    16'd0,    32'd0,         32'd0};
        tab[4] = '{16'hFFFF, 16'd0,    32'd1,         32'd0};
        tab[5] = '{16'h7FFF, 16'h7FFF, 32'h7FFE_0002, 32'h07FF_E000};
        tab[6] = '{16'h8000, 16'd0,    32'h4000_0000, 32'h0400_0000};
        tab[7] = '{16'd7,    16'hFFE8, 32'd625,       32'd39};
        tab[8] = '{16'd2,    16'd2,    32'd8,         32'd1};
        tab[9] = '{16'hFED4, 16'd400,  32'd250000,    32'd15625};

        #2;
        chk("rst_power", 64'(power_out), 64'(0));
        chk("rst_k", 64'(k_out), 64'(0));
        chk("rst_valid", 64'(valid_out), 64'(0));
        chk("rst_done", 64'(frame_done_out), 64'(0));
        chk("rst_err", 64'(err_out), 64'(0));
        chk("rst_tready", 64'(fft_tready_out), 64'(0));
        idle(2);
        rst_in = 1'b1;
        idle(2);
        chk("tready_after_release", 64'(fft_tready_out), 64'(1));

        // Table-driven frame: bins 0..NT-1 carry the vectors, the rest are flat
        s = vq_pow.size(); ds = dq_k.size();
        frame(N, N - 1, 1'b0, 1'b1, acc);
        idle(6);
        check_frame("table", s, ds, 512, 1, 1'b1);
        if (vq_cyc.size() > s) chk("latency", 64'(vq_cyc[s] - acc), 64'(3));
        for (int i = 0; i < NT; i++) begin
            if (vq_pow.size() > s + i) begin
`ifdef FFT_POWER_SHIFT_EN
                chk($sformatf("tab_pow_%0d", i), 64'(vq_pow[s+i]), 64'(tab[i].exp_shr));
`else
                chk($sformatf("tab_pow_%0d", i), 64'(vq_pow[s+i]), 64'(tab[i].exp_raw));
`endif
            end
        end
        chk("table_err", 64'(err_out), 64'(0));

        // Gapped tvalid
        s = vq_pow.size(); ds = dq_k.size();
        frame(N, N - 1, 1'b1, 1'b0, acc);
        idle(6);
        check_frame("gapped", s, ds, 512, 1, 1'b0);
        chk("gapped_err", 64'(err_out), 64'(0));

        // Early tlast on bin 300, then a normal frame
        s = vq_pow.size(); ds = dq_k.size();
        frame(301, 300, 1'b0, 1'b0, acc);
        idle(6);
        chk("early_err", 64'(err_out), 64'(1));
        check_frame("early", s, ds, 301, 0, 1'b0);
        s = vq_pow.size(); ds = dq_k.size();
        frame(N, N - 1, 1'b0, 1'b0, acc);
        idle(6);
        check_frame("after_early", s, ds, 512, 1, 1'b0);

        // Reset in the middle of a frame, right after bin 200 is accepted
        s = vq_pow.size();
        frame(201, -1, 1'b0, 1'b0, acc);
        rst_in = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid_out), 64'(0));
        chk("midrst_power", 64'(power_out), 64'(0));
        chk("midrst_err", 64'(err_out), 64'(0));
        chk("midrst_done", 64'(frame_done_out), 64'(0));
        chk("midrst_tready", 64'(fft_tready_out), 64'(0));
        idle(2);
        rst_in = 1'b1;
        idle(6);
        chk("midrst_frame_valids", 64'(vq_pow.size() - s), 64'(198));
        s = vq_pow.size(); ds = dq_k.size();
        frame(N, N - 1, 1'b0, 1'b0, acc);
        idle(6);
        check_frame("after_rst", s, ds, 512, 1, 1'b0);
        chk("after_rst_err", 64'(err_out), 64'(0));

        // Missing tlast at bin 1023, 50 discarded beats, tlast to recover, normal frame
        s = vq_pow.size(); ds = dq_k.size();
        frame(N, -1, 1'b0, 1'b0, acc);
        idle(6);
        chk("missing_err", 64'(err_out), 64'(1));
        check_frame("missing", s, ds, 512, 1, 1'b0);
        s = vq_pow.size();
        frame(50, -1, 1'b0, 1'b0, acc);
        drive(16'd100, 16'd0, 1'b1);
        idle(6);
        chk("resync_valids", 64'(vq_pow.size() - s), 64'(0));
        s = vq_pow.size(); ds = dq_k.size();
        frame(N, N - 1, 1'b0, 1'b0, acc);
        idle(6);
        check_frame("after_resync", s, ds, 512, 1, 1'b0);

        chk("power_zero_when_idle", 64'(zero_viol), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
